if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the ID-stage forwarding/branch unit.
- Owns the PC register.
- Drives the synchronous-read instruction ROM and holds the IF/ID pipeline register.
- Consumes the ID stage's branch/jump redirect (jmp, dest) and the load-use stall (id_ex_hazard_mem).

---
 rtl/if_stage.sv | 138 +++++++++++++
 tb/tb_if_stage.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage : instruction-fetch stage of the 5-stage MIPS pipeline.
//
// Owns the fetch PC, drives the synchronous-read instruction ROM and holds
// the IF/ID pipeline register. Redirects (jmp/dest) and the load-use stall
// come from the ID stage.
//
// Optional feature macro: DELAY_SLOT_EN
//   defined   : on a taken jmp the delay-slot word is passed on to ID.
//   undefined : on a taken jmp the delay-slot word is squashed (one bubble).
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   stall      in   load-use stall from ID; holds PC and IF/ID
//   jmp        in   taken branch/jump resolved in ID this cycle
//   dest       in   redirect target, valid when jmp=1
//   inst_en    out  ROM read enable
//   inst_addr  out  ROM byte address (bits [1:0] forced to 0)
//   inst_rdata in   ROM data for the address presented last cycle
//   id_pc      out  PC of the instruction held in IF/ID
//   id_inst    out  instruction held in IF/ID (0 for a bubble)
//   id_valid   out  IF/ID holds a real instruction
//   id_adel    out  sticky: fetch halted on a misaligned redirect target
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        jmp,
  input  logic [31:0] dest,
  output logic        inst_en,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_rdata,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid,
  output logic        id_adel
);

  typedef enum logic {RUN, HALT} state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [31:0] r_pcF;
  logic [31:0] w_nextPc;
  logic [31:0] r_idPc;
  logic [31:0] r_idInst;
  logic        r_idValid;
  logic        r_idAdel;
  logic        w_redirect;
  logic        w_misaligned;

  // A redirect is only honoured while running and not stalled; a stall
  // drops the jmp and ID re-asserts it once the stall clears.
  assign w_redirect   = (r_state == RUN) && !stall && jmp;
  assign w_misaligned = w_redirect && (dest[1:0] != 2'b00);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: HALT is entered on a misaligned redirect and is left
  // only through reset.
  always_comb begin
    w_nextState = r_state;
    if (w_misaligned) begin
      w_nextState = HALT;
    end
  end

  // Output logic: next fetch address and ROM enable. The ROM is also read
  // during reset so that RESET_PC's word is ready on the first run cycle.
  always_comb begin
    w_nextPc = r_pcF + 32'd4;
    inst_en  = 1'b1;
    if (reset) begin
      w_nextPc = RESET_PC;
    end else if (r_state == HALT) begin
      w_nextPc = r_pcF;
      inst_en  = 1'b0;
    end else if (stall) begin
      w_nextPc = r_pcF;
    end else if (jmp) begin
      w_nextPc = dest;
    end
  end

  assign inst_addr = w_nextPc & ~32'h0000_0003;

  // Fetch PC and IF/ID register. pc_f always names the word currently on
  // inst_rdata, so re-reading it during a stall keeps the pair coherent.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pcF     <= RESET_PC;
      r_idPc    <= 32'h0;
      r_idInst  <= 32'h0;
      r_idValid <= 1'b0;
      r_idAdel  <= 1'b0;
    end else if (r_state == HALT) begin
      r_idInst  <= 32'h0;
      r_idValid <= 1'b0;
    end else if (stall) begin
      r_pcF     <= r_pcF;
    end else if (jmp) begin
      r_pcF  <= dest;
      r_idPc <= r_pcF;
`ifdef DELAY_SLOT_EN
      r_idInst  <= inst_rdata;
      r_idValid <= 1'b1;
`else
      r_idInst  <= 32'h0;
      r_idValid <= 1'b0;
`endif
      if (w_misaligned) begin
        r_idAdel <= 1'b1;
      end
    end else begin
      r_pcF     <= w_nextPc;
      r_idPc    <= r_pcF;
      r_idInst  <= inst_rdata;
      r_idValid <= 1'b1;
    end
  end

  assign id_pc    = r_idPc;
  assign id_inst  = r_idInst;
  assign id_valid = r_idValid;
  assign id_adel  = r_idAdel;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        jmp = 1'b0;
  logic [31:0] dest = 32'h0;
  logic        inst_en;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata = 32'h0;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        id_adel;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
    logic        adel;
    logic [31:0] addr;
    logic        en;
  } exp_t;

  exp_t expQ[$];
  int   passCount = 0;
  int   totalCount = 0;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .jmp        (jmp),
    .dest       (dest),
    .inst_en    (inst_en),
    .inst_addr  (inst_addr),
    .inst_rdata (inst_rdata),
    .id_pc      (id_pc),
    .id_inst    (id_inst),
    .id_valid   (id_valid),
    .id_adel    (id_adel)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Synchronous ROM whose word i holds the value i.
  always @(posedge clk) begin
    if (inst_en) inst_rdata <= inst_addr >> 2;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
  endtask

  // Monitor: every cycle the DUT presents outputs, compare against the
  // next queued expectation on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("id_pc",     id_pc,            e.pc);
      checkOutput("id_inst",   id_inst,          e.inst);
      checkOutput("id_valid",  {31'b0, id_valid}, {31'b0, e.valid});
      checkOutput("id_adel",   {31'b0, id_adel},  {31'b0, e.adel});
      checkOutput("inst_addr", inst_addr,        e.addr);
      checkOutput("inst_en",   {31'b0, inst_en},  {31'b0, e.en});
    end
  end

  // Drive one cycle of inputs and queue the outputs expected in that cycle.
  task automatic applyStimulus(input logic r, input logic s, input logic j, input logic [31:0] d,
                               input logic [31:0] ePc, input logic [31:0] eInst,
                               input logic eValid, input logic eAdel,
                               input logic [31:0] eAddr, input logic eEn);
    exp_t e;
    @(posedge clk);
    #1;
    reset = r; stall = s; jmp = j; dest = d;
    e.pc = ePc; e.inst = eInst; e.valid = eValid; e.adel = eAdel;
    e.addr = eAddr; e.en = eEn;
    expQ.push_back(e);
  endtask

  initial begin
    logic [31:0] dsInst13, dsInst17, dsInst20;
    logic        dsValid;
`ifdef DELAY_SLOT_EN
    dsValid = 1'b1; dsInst13 = 32'h9; dsInst17 = 32'h42; dsInst20 = 32'h82;
`else
    dsValid = 1'b0; dsInst13 = 32'h0; dsInst17 = 32'h0;  dsInst20 = 32'h0;
`endif
    // first reset edge: registers not yet defined, nothing checked
    @(posedge clk);
    #1;
    //             r  s  j  dest            pc       inst     v  adel addr     en
    applyStimulus(1, 0, 0, 32'h0,          32'h0,   32'h0,   0, 0,   32'h0,   1);
    // normal fetch
    applyStimulus(0, 0, 0, 32'h0,          32'h0,   32'h0,   0, 0,   32'h4,   1);
    applyStimulus(0, 0, 0, 32'h0,          32'h0,   32'h0,   1, 0,   32'h8,   1);
    applyStimulus(0, 0, 0, 32'h0,          32'h4,   32'h1,   1, 0,   32'hC,   1);
    // two-cycle stall while id_pc=0x8
    applyStimulus(0, 1, 0, 32'h0,          32'h8,   32'h2,   1, 0,   32'hC,   1);
    applyStimulus(0, 1, 0, 32'h0,          32'h8,   32'h2,   1, 0,   32'hC,   1);
    applyStimulus(0, 0, 0, 32'h0,          32'h8,   32'h2,   1, 0,   32'h10,  1);
    applyStimulus(0, 0, 0, 32'h0,          32'hC,   32'h3,   1, 0,   32'h14,  1);
    applyStimulus(0, 0, 0, 32'h0,          32'h10,  32'h4,   1, 0,   32'h18,  1);
    applyStimulus(0, 0, 0, 32'h0,          32'h14,  32'h5,   1, 0,   32'h1C,  1);
    applyStimulus(0, 0, 0, 32'h0,          32'h18,  32'h6,   1, 0,   32'h20,  1);
    applyStimulus(0, 0, 0, 32'h0,          32'h1C,  32'h7,   1, 0,   32'h24,  1);
    // jump to 0x100 while id_pc=0x20
    applyStimulus(0, 0, 1, 32'h100,        32'h20,  32'h8,   1, 0,   32'h100, 1);
    applyStimulus(0, 0, 0, 32'h0,          32'h24,  dsInst13, dsValid, 0, 32'h104, 1);
    applyStimulus(0, 0, 0, 32'h0,          32'h100, 32'h40,  1, 0,   32'h108, 1);
    // stall+jmp together: redirect dropped, then jmp alone
    applyStimulus(0, 1, 1, 32'h200,        32'h104, 32'h41,  1, 0,   32'h108, 1);
    applyStimulus(0, 0, 1, 32'h200,        32'h104, 32'h41,  1, 0,   32'h200, 1);
    applyStimulus(0, 0, 0, 32'h0,          32'h108, dsInst17, dsValid, 0, 32'h204, 1);
    applyStimulus(0, 0, 0, 32'h0,          32'h200, 32'h80,  1, 0,   32'h208, 1);
    // misaligned redirect
    applyStimulus(0, 0, 1, 32'h102,        32'h204, 32'h81,  1, 0,   32'h100, 1);
    applyStimulus(0, 0, 1, 32'h300,        32'h208, dsInst20, dsValid, 1, 32'h100, 0);
    applyStimulus(0, 1, 0, 32'h0,          32'h208, 32'h0,   0, 1,   32'h100, 0);
    applyStimulus(0, 0, 1, 32'h400,        32'h208, 32'h0,   0, 1,   32'h100, 0);
    // reset leaves HALT
    applyStimulus(1, 0, 0, 32'h0,          32'h208, 32'h0,   0, 1,   32'h0,   1);
    applyStimulus(0, 0, 0, 32'h0,          32'h0,   32'h0,   0, 0,   32'h4,   1);
    applyStimulus(0, 0, 0, 32'h0,          32'h0,   32'h0,   1, 0,   32'h8,   1);
    // reset while stalled with a valid instruction in IF/ID
    applyStimulus(1, 1, 0, 32'h0,          32'h4,   32'h1,   1, 0,   32'h0,   1);
    applyStimulus(0, 0, 0, 32'h0,          32'h0,   32'h0,   0, 0,   32'h4,   1);
    applyStimulus(0, 0, 0, 32'h0,          32'h0,   32'h0,   1, 0,   32'h8,   1);
    applyStimulus(0, 0, 0, 32'h0,          32'h4,   32'h1,   1, 0,   32'hC,   1);

    // let the monitor drain the queue, bounded
    for (int k = 0; k < 10 && expQ.size() > 0; k++) @(posedge clk);
    if (expQ.size() > 0) begin
      totalCount++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
    end
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
